alu_seq_exec: RTL and testbench
===============================

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept.
- alu_control  in  3  op code: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT, 101 MUL, 011 DIV (see REQ-019).
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- err  out  1  illegal op code for this result.

Function
REQ-004 SHALL accept an op on a rising edge where in_valid && in_ready; it SHALL capture alu_control, src_a and src_b on that edge.
REQ-005 SHALL have states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-006 On acceptance of ADD/SUB/AND/OR/SLT in cycle N, it SHALL go IDLE->DONE and assert out_valid in cycle N+1.
REQ-007 ADD and SUB SHALL wrap modulo 2^WIDTH; SLT SHALL compare signed and return 1 or 0 zero-extended.
REQ-008 MUL SHALL be an iterative shift-add of unsigned operands, one bit per cycle, WIDTH iterations; result SHALL be the low WIDTH bits; out_valid SHALL assert in cycle N+1+WIDTH.
REQ-009 An iteration counter of ceil(log2(WIDTH))+1 bits SHALL count 0..WIDTH-1 and SHALL leave MUL/DIV after the final iteration.
REQ-010 In DONE, result, zero and err SHALL be stable while out_valid=1 and out_ready=0.
REQ-011 DONE->IDLE SHALL occur on the edge where out_valid && out_ready; in_ready SHALL rise the following cycle; there is no same-cycle accept.
REQ-012 in_valid while in_ready=0 SHALL be ignored, with no state change.
REQ-013 Op code 100, and 011 when DIV is compiled out, SHALL go IDLE->DONE with result=0, zero=1, err=1.
REQ-014 err SHALL be 0 for every legal op.
REQ-015 Input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-016 Asserting rst_n low SHALL force IDLE immediately, in any state including mid-MUL/DIV, aborting the op with no result produced.
REQ-017 Reset values: in_ready=1 (once rst_n is high), out_valid=0, result=0, zero=1, err=0, counter=0.
REQ-018 Deassertion of rst_n is treated as synchronized externally.

Configuration
REQ-019 Macro ALU_DIV_EN defined: op 011 SHALL be an unsigned restoring divide, one quotient bit per cycle, WIDTH iterations, out_valid at N+1+WIDTH; result is the quotient; src_b==0 SHALL give result all-ones with err=0.
REQ-020 Macro ALU_DIV_EN undefined: no divide logic or DIV state SHALL exist, and 011 SHALL follow REQ-013.

Structure
REQ-021 Shared package alu_pkg SHALL hold the alu_control encodings as named constants and the state enumeration.
REQ-022 Iterative MUL/DIV datapath (shift registers, counter) SHALL live in sub-module alu_iter_muldiv; single-cycle ops and the FSM SHALL stay in alu_seq_exec.

Verification
REQ-023 ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid at N+1, result=0, zero=1, err=0.
REQ-024 SLT 0xFFFFFFFF vs 0x00000001 -> result=1; MUL 0x00010003*0x00020005 -> result 0x000B000F at cycle N+33, in_ready=0 throughout.
REQ-025 ADD with out_ready held 0 for 5 cycles -> result stable, in_ready=0; in_ready=1 one cycle after the handshake.
REQ-026 rst_n low at iteration 10 of MUL -> immediate IDLE, out_valid=0; next op ADD 2+3 -> result 5.
REQ-027 Op 100 -> result 0, err=1. With ALU_DIV_EN: 100/7 -> 14 at N+33, and 5/0 -> 0xFFFFFFFF. Without ALU_DIV_EN: op 011 -> err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code encodings and FSM state type for the sequential ALU.
// ALU_DIV_EN adds the DIV state (restoring divide on op 011).
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
`ifdef ALU_DIV_EN
    DIV,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: shift-add multiply (and restoring divide if ALU_DIV_EN).
// Ports: start loads a/b, run steps once, last flags final step, res_nxt.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] res_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, dv;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rsh, dif;
`endif

  // {hi,lo} shifts right; lo starts as the multiplier/dividend and
  // ends holding the low product word or the quotient.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, dv} : '0);
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    rsh = {hi, lo[WIDTH-1]};
    dif = rsh - {1'b0, dv};
    if (div_q) begin
      if (rsh >= {1'b0, dv}) begin
        hi_n = dif[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rsh[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign last    = (cnt == CW'(WIDTH - 1));
  assign res_nxt = lo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      dv  <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= a;
      dv  <= b;
`ifdef ALU_DIV_EN
      div_q <= is_div;
`endif
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR/SLT, iterative MUL (and DIV
// with ALU_DIV_EN); valid/ready in and out, result/zero/err held in DONE.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  state_t           state, state_n;
  logic [WIDTH-1:0] res_q, alu_res, iter_res;
  logic             err_q, illegal, iter_op;
  logic             start, run, last;

  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    iter_op = 1'b0;
    unique case (alu_control)
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}},
                         $signed(src_a) < $signed(src_b)};
      OP_MUL: iter_op = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV: iter_op = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
`ifdef ALU_DIV_EN
  assign run = (state == MUL) || (state == DIV);
`else
  assign run = (state == MUL);
`endif

  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        start = iter_op;
        if (alu_control == OP_MUL) state_n = MUL;
`ifdef ALU_DIV_EN
        else if (alu_control == OP_DIV) state_n = DIV;
`endif
        else state_n = DONE;
      end
      MUL: if (last) state_n = DONE;
`ifdef ALU_DIV_EN
      DIV: if (last) state_n = DONE;
`endif
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (in_valid && in_ready) begin
        res_q <= alu_res;
        err_q <= illegal;
      end else if (run && last) begin
        res_q <= iter_res;
      end
    end
  end

  assign result = res_q;
  assign zero   = (res_q == '0);
  assign err    = err_q;

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef ALU_DIV_EN
    .is_div  (alu_control == OP_DIV),
`endif
    .run     (run),
    .a       (src_a),
    .b       (src_b),
    .last    (last),
    .res_nxt (iter_res)
  );

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: expected results queued on accept,
// popped and compared at the output handshake.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_control = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        err;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [31:0] a, b);
    exp_t e;
    logic [63:0] p;
    e.res = '0; e.err = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      3'b010: e.res = a + b;
      3'b110: e.res = a - b;
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.lat = 33;
      end
`ifdef ALU_DIV_EN
      3'b011: begin
        e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
        e.lat = 33;
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b);
    exp_t e;
    @(negedge clk);
    check("idle_rdy", in_ready, 1);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    e = model(op, a, b);
    @(posedge clk);
    #1;
    e.acc = ecnt;
    sb.push_back(e);
    in_valid = 1'b0;
    alu_control = 3'($urandom);
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   n;
    bit   busy_ok;
    n = 0; busy_ok = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("out_valid", out_valid, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("latency", ecnt - e.acc + 1, e.lat);
    check("busy_rdy", busy_ok, 1);
    for (int i = 0; i < hold; i++) begin
      check("hold_res", result, e.res);
      check("hold_rdy", in_ready, 0);
      @(negedge clk);
    end
    check("result", result, e.res);
    check("zero", zero, e.res == 0);
    check("err", err, e.err);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rdy_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b);
    issue(op, a, b);
    collect(0);
  endtask

  initial begin
    #12;
    check("rst_rdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_res", result, 0);
    check("rst_zero", zero, 1);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(3'b110, 32'h0000_0000, 32'h0000_0001);
    run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(3'b001, 32'hF000_0001, 32'h0000_1230);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op(3'b111, 32'h0000_0005, 32'h0000_0005);

    issue(3'b101, 32'h0001_0003, 32'h0002_0005);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_control = 3'b010;
    end
    @(negedge clk);
    in_valid = 1'b0;
    collect(0);

    run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++)
      run_op(3'b101, $urandom, $urandom);

    run_op(3'b100, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(3'b011, 32'd100, 32'd7);
    run_op(3'b011, 32'd5, 32'd0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0010);

    issue(3'b010, 32'h0000_1000, 32'h0000_0234);
    collect(5);

    issue(3'b101, 32'h1234_5678, 32'h0000_0FFF);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_rdy", in_ready, 1);
    check("abort_res", result, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_valid", out_valid, 0);
    run_op(3'b010, 32'd2, 32'd3);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
